rename_free_list_ckpt: RTL and testbench

//  Physical-register free list for the rename stage, generalised in pool size and port count.

---
 rtl/rename_free_list_ckpt_pkg.sv | 34 +++
 rtl/rename_free_list_ckpt_pick.sv | 36 +++
 rtl/rename_free_list_ckpt.sv | 172 +++++++++++++++++
 tb/tb_rename_free_list_ckpt.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/rename_free_list_ckpt_pkg.sv
// Shared helpers for the rename free list.
//   pb_w/ab_w/cb_w/nb_w : index/count widths derived from the pool parameters
//   popcount            : set-bit count of a (zero-extended) preg vector
package rename_free_list_ckpt_pkg;

  // Widest pool popcount() accepts; narrower vectors are zero-extended.
  localparam int unsigned POP_MAX_W = 1024;

  // Index width of an n-entry space; never below 1 bit.
  function automatic int unsigned pb_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Width able to hold the count value n itself.
  function automatic int unsigned ab_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  function automatic int unsigned cb_w(input int unsigned n);
    return pb_w(n);
  endfunction

  function automatic int unsigned nb_w(input int unsigned n);
    return ab_w(n);
  endfunction

  function automatic int unsigned popcount(input logic [POP_MAX_W-1:0] v);
    int unsigned c;
    c = 0;
    for (int i = 0; i < POP_MAX_W; i++) c += int'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/rename_free_list_ckpt_pick.sv
// pick_lowest_n: selects the K lowest set bits of a free vector.
//   free_i   : candidate vector
//   onehot_o : per slot one-hot mask of the selected bit (0 if none left)
//   idx_o    : per slot encoded index of that bit (0 if none left)
//   found_o  : per slot, a bit was available
// Slot k sees the vector with the bits chosen by slots 0..k-1 cleared.
module pick_lowest_n
  import rename_free_list_ckpt_pkg::*;
#(
  parameter int unsigned N  = 64,
  parameter int unsigned K  = 4,
  localparam int unsigned PB = pb_w(N)
) (
  input  logic [N-1:0]           free_i,
  output logic [K-1:0][N-1:0]    onehot_o,
  output logic [K-1:0][PB-1:0]   idx_o,
  output logic [K-1:0]           found_o
);

  always_comb begin
    logic [N-1:0] rem;
    rem      = free_i;
    onehot_o = '0;
    idx_o    = '0;
    found_o  = '0;
    for (int k = 0; k < K; k++) begin
      // two's-complement trick isolates the lowest set bit
      onehot_o[k] = rem & (~rem + N'(1));
      found_o[k]  = |rem;
      for (int i = 0; i < N; i++)
        if (onehot_o[k][i]) idx_o[k] = idx_o[k] | PB'(i);
      rem = rem & ~onehot_o[k];
    end
  end

endmodule

// File: rtl/rename_free_list_ckpt.sv
// rename_free_list_ckpt: physical-register free list with branch checkpoints.
//   i_clk/i_rst                 clock, async active-high reset
//   i_ret_valid/i_ret_preg      up to RET_W pregs freed per cycle by commit
//   i_alloc_valid/i_alloc_count allocation request (1..ALLOC_W pregs)
//   o_alloc_ready               request accepted this cycle
//   o_alloc_vld/o_alloc_preg    registered grant, one cycle after acceptance
//   i_ckpt_take/i_ckpt_id       open a checkpoint
//   i_restore/i_restore_id      mispredict: free every preg granted since the checkpoint
//   i_ckpt_release              close checkpoints (mask)
//   o_avail_count               registered number of free pregs
//   o_err_dbl_free              sticky double-free flag
module rename_free_list_ckpt
  import rename_free_list_ckpt_pkg::*;
#(
  parameter int unsigned NUM_PREGS = 64,
  parameter int unsigned NUM_ARCH  = 32,
  parameter int unsigned ALLOC_W   = 4,
  parameter int unsigned RET_W     = 4,
  parameter int unsigned NUM_CKPT  = 4,
  localparam int unsigned PB = pb_w(NUM_PREGS),
  localparam int unsigned AB = ab_w(ALLOC_W),
  localparam int unsigned CB = cb_w(NUM_CKPT),
  localparam int unsigned NB = nb_w(NUM_PREGS)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [RET_W-1:0]      i_ret_valid,
  input  logic [RET_W*PB-1:0]   i_ret_preg,
  input  logic                  i_alloc_valid,
  input  logic [AB-1:0]         i_alloc_count,
  output logic                  o_alloc_ready,
  output logic [ALLOC_W-1:0]    o_alloc_vld,
  output logic [ALLOC_W*PB-1:0] o_alloc_preg,
  input  logic                  i_ckpt_take,
  input  logic [CB-1:0]         i_ckpt_id,
  input  logic                  i_restore,
  input  logic [CB-1:0]         i_restore_id,
  input  logic [NUM_CKPT-1:0]   i_ckpt_release,
  output logic [NB-1:0]         o_avail_count,
  output logic                  o_err_dbl_free
);

  typedef struct packed {
    logic                 valid;
    logic [NUM_PREGS-1:0] since;  // pregs granted after this branch
  } ckpt_t;

  function automatic logic [NUM_PREGS-1:0] reset_free();
    logic [NUM_PREGS-1:0] f;
    for (int i = 0; i < NUM_PREGS; i++) f[i] = (i >= NUM_ARCH);
    return f;
  endfunction

  logic [NUM_PREGS-1:0]        free_q, free_d;
  logic [NB-1:0]               avail_q, avail_d;
  logic [ALLOC_W-1:0]          vld_q, vld_d;
  logic [ALLOC_W-1:0][PB-1:0]  preg_q, preg_d;
  logic                        err_q, err_d;
  ckpt_t                       ckpt_q [NUM_CKPT];
  ckpt_t                       ckpt_d [NUM_CKPT];

  logic [ALLOC_W-1:0][NUM_PREGS-1:0] pick_oh;
  logic [ALLOC_W-1:0][PB-1:0]        pick_idx;
  logic [ALLOC_W-1:0]                pick_found;

  logic                 fire;
  logic [AB-1:0]        eff_cnt;
  logic [ALLOC_W-1:0]   slot_grant;
  logic [NUM_PREGS-1:0] grant_mask, ret_mask, restore_mask;
  logic                 dbl;
  logic                 take_en;

  // Selection looks only at the registered free vector, so same-cycle
  // retires can never be handed out before they are registered.
  pick_lowest_n #(.N(NUM_PREGS), .K(ALLOC_W)) u_pick (
    .free_i   (free_q),
    .onehot_o (pick_oh),
    .idx_o    (pick_idx),
    .found_o  (pick_found)
  );

  // Ready needs a full ALLOC_W worth of pregs regardless of count, which
  // keeps it a function of registered state (plus restore) only.
  assign o_alloc_ready = !i_restore && (avail_q >= NB'(ALLOC_W));
  assign fire          = i_alloc_valid && o_alloc_ready;
  assign eff_cnt       = (i_alloc_count > AB'(ALLOC_W)) ? AB'(ALLOC_W) : i_alloc_count;
  assign take_en       = i_ckpt_take && !i_restore;

  always_comb begin
    for (int k = 0; k < ALLOC_W; k++)
      slot_grant[k] = fire && (AB'(k) < eff_cnt) && pick_found[k];
  end

  always_comb begin
    grant_mask = '0;
    vld_d      = '0;
    preg_d     = '0;
    for (int k = 0; k < ALLOC_W; k++) begin
      if (slot_grant[k]) begin
        grant_mask = grant_mask | pick_oh[k];
        vld_d[k]   = 1'b1;
        preg_d[k]  = pick_idx[k];
      end
    end
  end

  // Retire decode; a preg already free, or already named by a lower slot
  // this cycle, is a double free. The bit is still marked free.
  always_comb begin
    logic [PB-1:0] p;
    p        = '0;
    ret_mask = '0;
    dbl      = 1'b0;
    for (int r = 0; r < RET_W; r++) begin
      if (i_ret_valid[r]) begin
        p = i_ret_preg[r*PB +: PB];
        if (free_q[p] || ret_mask[p]) dbl = 1'b1;
        ret_mask[p] = 1'b1;
      end
    end
  end

  assign restore_mask = i_restore ? ckpt_q[i_restore_id].since : '0;
  assign free_d       = (free_q & ~grant_mask) | ret_mask | restore_mask;
  assign avail_d      = NB'(popcount(POP_MAX_W'(free_d)));
  assign err_d        = err_q | dbl;

  // Priority (lowest to highest): accumulate grants, take, release, restore.
  // A take clears since[], so grants in its own cycle are never recorded.
  always_comb begin
    for (int j = 0; j < NUM_CKPT; j++) begin
      ckpt_d[j] = ckpt_q[j];
      if (ckpt_q[j].valid) ckpt_d[j].since = ckpt_q[j].since | grant_mask;
      if (take_en && (i_ckpt_id == CB'(j))) begin
        ckpt_d[j].valid = 1'b1;
        ckpt_d[j].since = '0;
      end
      if (i_ckpt_release[j]) begin
        ckpt_d[j].valid = 1'b0;
        ckpt_d[j].since = '0;
      end
      if (i_restore && (i_restore_id == CB'(j))) begin
        ckpt_d[j].valid = 1'b0;
        ckpt_d[j].since = '0;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      free_q  <= reset_free();
      avail_q <= NB'(NUM_PREGS - NUM_ARCH);
      vld_q   <= '0;
      preg_q  <= '0;
      err_q   <= 1'b0;
      for (int j = 0; j < NUM_CKPT; j++) ckpt_q[j] <= '0;
    end else begin
      free_q  <= free_d;
      avail_q <= avail_d;
      vld_q   <= vld_d;
      preg_q  <= preg_d;
      err_q   <= err_d;
      for (int j = 0; j < NUM_CKPT; j++) ckpt_q[j] <= ckpt_d[j];
    end
  end

  assign o_alloc_vld    = vld_q;
  assign o_alloc_preg   = preg_q;
  assign o_avail_count  = avail_q;
  assign o_err_dbl_free = err_q;

endmodule

// File: tb/tb_rename_free_list_ckpt.sv
module tb_rename_free_list_ckpt;
  localparam int NP = 64, NA = 32, AW = 4, RW = 4, NC = 4;
  localparam int PB = 6, AB = 3, CB = 2, NB = 7;

  logic             clk = 1'b0;
  logic             rst;
  logic [RW-1:0]    ret_valid;
  logic [RW*PB-1:0] ret_preg;
  logic             alloc_valid;
  logic [AB-1:0]    alloc_count;
  logic             alloc_ready;
  logic [AW-1:0]    alloc_vld;
  logic [AW*PB-1:0] alloc_preg;
  logic             ckpt_take;
  logic [CB-1:0]    ckpt_id;
  logic             restore;
  logic [CB-1:0]    restore_id;
  logic [NC-1:0]    ckpt_release;
  logic [NB-1:0]    avail_count;
  logic             err_dbl;

  int checks = 0;
  int errors = 0;

  rename_free_list_ckpt #(
    .NUM_PREGS(NP), .NUM_ARCH(NA), .ALLOC_W(AW), .RET_W(RW), .NUM_CKPT(NC)
  ) dut (
    .i_clk(clk), .i_rst(rst),
    .i_ret_valid(ret_valid), .i_ret_preg(ret_preg),
    .i_alloc_valid(alloc_valid), .i_alloc_count(alloc_count),
    .o_alloc_ready(alloc_ready), .o_alloc_vld(alloc_vld), .o_alloc_preg(alloc_preg),
    .i_ckpt_take(ckpt_take), .i_ckpt_id(ckpt_id),
    .i_restore(restore), .i_restore_id(restore_id),
    .i_ckpt_release(ckpt_release),
    .o_avail_count(avail_count), .o_err_dbl_free(err_dbl)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Requests outside 1..ALLOC_W are illegal stimulus.
  always @(posedge clk) begin
    if (!rst && alloc_valid)
      assert (alloc_count >= 1 && alloc_count <= AB'(AW))
      else begin
        errors++;
        $error("FAIL alloc_count_legal observed=%0d expected=1..%0d", alloc_count, AW);
      end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [AW*PB-1:0] pk4(input int a, input int b, input int c, input int d);
    logic [PB-1:0] s0, s1, s2, s3;
    s0 = PB'(a); s1 = PB'(b); s2 = PB'(c); s3 = PB'(d);
    return {s3, s2, s1, s0};
  endfunction

  task automatic clr;
    ret_valid = '0; ret_preg = '0; alloc_valid = 1'b0; alloc_count = 3'd1;
    ckpt_take = 1'b0; ckpt_id = '0; restore = 1'b0; restore_id = '0; ckpt_release = '0;
  endtask

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic alloc(input int n);
    alloc_valid = 1'b1; alloc_count = AB'(n);
  endtask

  task automatic ret(input int slot, input int p);
    ret_valid[slot] = 1'b1;
    ret_preg[slot*PB +: PB] = PB'(p);
  endtask

  initial begin
    clr();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // 1: reset state and first grant
    chk("rst_avail", avail_count, 32);
    chk("rst_vld", alloc_vld, 0);
    chk("rst_preg", alloc_preg, 0);
    chk("rst_err", err_dbl, 0);
    alloc(4); #1;
    chk("t1_ready", alloc_ready, 1);
    step(); clr();
    chk("t1_vld", alloc_vld, 4'b1111);
    chk("t1_preg", alloc_preg, pk4(32, 33, 34, 35));
    chk("t1_avail", avail_count, 28);
    step();
    chk("t1_vld_drop", alloc_vld, 0);

    // 2: drain to 3 free (36..60 taken), then a retire brings ready back
    for (int i = 0; i < 6; i++) begin alloc(4); step(); end
    alloc(1); step();
    chk("t2_last_preg", alloc_preg, pk4(60, 0, 0, 0));
    chk("t2_avail3", avail_count, 3);
    alloc(4); #1;
    chk("t2_ready0", alloc_ready, 0);
    step();
    chk("t2_no_grant", alloc_vld, 0);
    clr(); ret(0, 5); #1;
    chk("t2_ready_same_cycle", alloc_ready, 0);
    step(); clr(); #1;
    chk("t2_avail4", avail_count, 4);
    chk("t2_ready_after", alloc_ready, 1);
    alloc(1); step(); clr();
    chk("t2_vld", alloc_vld, 4'b0001);
    chk("t2_preg5", alloc_preg, pk4(5, 0, 0, 0));
    chk("t2_avail", avail_count, 3);

    // 3: free 32..39, take ckpt 2 with alloc 4, alloc 2, restore 2
    ret(0, 32); ret(1, 33); ret(2, 34); ret(3, 35); step();
    ret(0, 36); ret(1, 37); ret(2, 38); ret(3, 39); step(); clr();
    chk("t3_avail11", avail_count, 11);
    ckpt_take = 1'b1; ckpt_id = 2'd2; alloc(4); step(); clr();
    chk("t3_preg_a", alloc_preg, pk4(32, 33, 34, 35));
    alloc(2); step(); clr();
    chk("t3_preg_b", alloc_preg, pk4(36, 37, 0, 0));
    chk("t3_avail5", avail_count, 5);
    restore = 1'b1; restore_id = 2'd2; alloc(1); #1;
    chk("t3_ready_restore", alloc_ready, 0);
    step(); clr();
    chk("t3_restore_nogrant", alloc_vld, 0);
    chk("t3_avail7", avail_count, 7);
    alloc(4); step(); clr();
    chk("t3_regrant", alloc_preg, pk4(36, 37, 38, 39));
    chk("t3_avail3", avail_count, 3);
    chk("t3_err", err_dbl, 0);

    // 4: double free of 40, sticky; then duplicate in one cycle after reset
    ret(0, 40); step(); clr();
    chk("t4_legal_free", err_dbl, 0);
    chk("t4_avail4", avail_count, 4);
    ret(1, 40); step(); clr();
    chk("t4_dbl", err_dbl, 1);
    chk("t4_avail_still4", avail_count, 4);
    step();
    chk("t4_sticky", err_dbl, 1);
    rst = 1'b1; step(); rst = 1'b0;
    chk("t4_rst_err", err_dbl, 0);
    ret(0, 7); ret(2, 7); step(); clr();
    chk("t4_dup_slots", err_dbl, 1);
    chk("t4_avail33", avail_count, 33);

    // 5: take 0, take 1, alloc 3, release 1, restore 0
    ckpt_take = 1'b1; ckpt_id = 2'd0; step();
    ckpt_id = 2'd1; step(); clr();
    alloc(3); step(); clr();
    chk("t5_vld", alloc_vld, 4'b0111);
    chk("t5_preg", alloc_preg, pk4(7, 32, 33, 0));
    chk("t5_avail30", avail_count, 30);
    ckpt_release = 4'b0010; step(); clr();
    restore = 1'b1; restore_id = 2'd0; step(); clr();
    chk("t5_restore0", avail_count, 33);
    alloc(3); step(); clr();
    chk("t5_regrant", alloc_preg, pk4(7, 32, 33, 0));
    restore = 1'b1; restore_id = 2'd1; step(); clr();
    chk("t5_ckpt1_closed", avail_count, 30);
    restore = 1'b1; restore_id = 2'd0; step(); clr();
    chk("t5_ckpt0_closed", avail_count, 30);

    // 6: async reset with open checkpoint and a pending grant
    ckpt_take = 1'b1; ckpt_id = 2'd3; alloc(4); step(); clr();
    chk("t6_preg_a", alloc_preg, pk4(34, 35, 36, 37));
    alloc(4); step(); clr();
    chk("t6_vld", alloc_vld, 4'b1111);
    chk("t6_avail22", avail_count, 22);
    #2 rst = 1'b1; #1;
    chk("t6_rst_vld", alloc_vld, 0);
    chk("t6_rst_preg", alloc_preg, 0);
    chk("t6_rst_avail", avail_count, 32);
    chk("t6_rst_err", err_dbl, 0);
    @(posedge clk); #1 rst = 1'b0;
    alloc(4); step(); clr();
    chk("t6_post_preg", alloc_preg, pk4(32, 33, 34, 35));
    restore = 1'b1; restore_id = 2'd3; step(); clr();
    chk("t6_ckpt3_cleared", avail_count, 28);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
